frac_logic_slice_array: RTL and testbench

//  Parametrised fracturable logic element: NUM_FRAC slices, each with a (LUT_K-1)-input truth table,
//  a pair of (LUT_K-2) fragments driving a p/g ripple-carry stage, a 4:1 output mux and an optional output FF.

---
 rtl/frac_logic_pkg.sv | 47 ++++
 rtl/frac_logic_slice_array_if.sv | 13 +
 rtl/frac_logic_slice.sv | 65 ++++++
 rtl/frac_logic_slice_array.sv | 128 ++++++++++++
 tb/tb_frac_logic_slice_array.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frac_logic_pkg.sv
// Shared sizing helpers, config field offsets and enums for the fracturable
// logic slice array.
package frac_logic_pkg;

  typedef enum logic [1:0] {
    SEL_SUM   = 2'd0,
    SEL_COUT  = 2'd1,
    SEL_LUTK1 = 2'd2,
    SEL_LUTK  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  // Truth table width of one slice: a (LUT_K-1)-input LUT.
  function automatic int tt_bits(input int k);
    return 2 ** (k - 1);
  endfunction

  // Field layout inside a slice: {reg_en, sel[1:0], tt}.
  function automatic int sel_off(input int k);
    return tt_bits(k);
  endfunction

  function automatic int reg_en_off(input int k);
    return tt_bits(k) + 2;
  endfunction

  function automatic int slice_bits(input int k);
    return tt_bits(k) + 3;
  endfunction

  function automatic int cfg_bits(input int k, input int n);
    return n * slice_bits(k);
  endfunction

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/frac_logic_slice_array_if.sv
// Config-chain bus: serial chain in/out, shift enable and commit status.
interface frac_logic_slice_array_if;
  logic config_enable;
  logic ccff_head;
  logic ccff_tail;
  logic cfg_done;
  logic cfg_err;

  modport master (output config_enable, ccff_head,
                  input  ccff_tail, cfg_done, cfg_err);
  modport slave  (input  config_enable, ccff_head,
                  output ccff_tail, cfg_done, cfg_err);
endinterface

// File: rtl/frac_logic_slice.sv
// One slice: truth table split into two fragments, p/g ripple-carry stage,
// 4:1 output mux and an optional output register.
module frac_logic_slice
  import frac_logic_pkg::*;
#(
  parameter int LUT_K = 6
) (
  input  logic                           prog_clock,
  input  logic                           prog_reset_n,
  input  logic                           config_enable,
  input  logic [slice_bits(LUT_K)-1:0]   cfg,
  input  logic [LUT_K-1:0]               lut_in,
  input  logic                           lutk1_nb,
  input  logic                           cin,
  output logic                           lutk1,
  output logic                           cout,
  output logic                           out
);
  localparam int TTB  = tt_bits(LUT_K);
  localparam int HALF = TTB / 2;

  logic [TTB-1:0]  tt;
  logic [HALF-1:0] tt_lo, tt_hi;
  sel_e            sel;
  logic            reg_en;
  logic            frag_lo, frag_hi, lutk, sum, mux, q;

  assign tt     = cfg[TTB-1:0];
  assign sel    = sel_e'(cfg[sel_off(LUT_K) +: 2]);
  assign reg_en = cfg[reg_en_off(LUT_K)];
  assign tt_lo  = tt[HALF-1:0];
  assign tt_hi  = tt[TTB-1:HALF];

  assign frag_lo = tt_lo[lut_in[LUT_K-3:0]];
  assign frag_hi = tt_hi[lut_in[LUT_K-3:0]];
  assign lutk1   = lut_in[LUT_K-2] ? frag_hi : frag_lo;
  // Top input borrows the neighbouring slice's half to form a full LUT_K LUT.
  assign lutk    = lut_in[LUT_K-1] ? lutk1_nb : lutk1;

  // Low fragment acts as propagate, high fragment as generate.
  assign sum  = frag_lo ^ cin;
  assign cout = frag_lo ? cin : frag_hi;

  // Output source select.
  always_comb begin
    mux = sum;
    case (sel)
      SEL_SUM:   mux = sum;
      SEL_COUT:  mux = cout;
      SEL_LUTK1: mux = lutk1;
      SEL_LUTK:  mux = lutk;
      default:   mux = sum;
    endcase
  end

  // Output register, parked at 0 while the chain is being shifted.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n)     q <= 1'b0;
    else if (config_enable) q <= 1'b0;
    else                    q <= mux;
  end

  assign out = reg_en ? q : mux;

endmodule

// File: rtl/frac_logic_slice_array.sv
// Fracturable logic element: NUM_FRAC chained slices plus a config chain with
// shadow/active double buffering and a commit checker.
// Optional macro FRAC_LOGIC_CFG_PARITY_EN: adds one parity bit at the head of
// the chain and requires even parity over the whole shadow to commit.
module frac_logic_slice_array
  import frac_logic_pkg::*;
#(
  parameter int LUT_K    = 6,
  parameter int NUM_FRAC = 2
) (
  input  logic                      prog_clock,
  input  logic                      prog_reset_n,
  frac_logic_slice_array_if.slave   cfg_bus,
  input  logic [LUT_K-1:0]          frac_logic_in,
  input  logic                      frac_logic_cin,
  output logic [NUM_FRAC-1:0]       frac_logic_out,
  output logic                      frac_logic_cout
);
  localparam int SB = slice_bits(LUT_K);
  localparam int CB = cfg_bits(LUT_K, NUM_FRAC);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int CHAIN = CB + 1;
`else
  localparam int CHAIN = CB;
`endif
  localparam int CW = clog2_f(CHAIN + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(CHAIN + 1);

  logic [CHAIN-1:0]    shadow;
  logic [CB-1:0]       active;
  logic [CW-1:0]       cnt;
  logic                done_q, err_q;
  cfg_state_e          state, state_nx;
  logic                clr, commit, commit_ok;
  logic                en;
  logic [NUM_FRAC:0]   carry;
  logic [NUM_FRAC-1:0] lutk1, slice_out;

  assign en = cfg_bus.config_enable;

`ifdef FRAC_LOGIC_CFG_PARITY_EN
  assign commit_ok = (cnt == CNT_FULL) && !(^shadow);
`else
  assign commit_ok = (cnt == CNT_FULL);
`endif

  // Commit FSM state register; SHIFT doubles as the registered enable.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) state <= ST_IDLE;
    else               state <= state_nx;
  end

  // Rising enable clears the counter/status, falling enable requests commit.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_SHIFT: if (!en) begin
        state_nx = ST_COMMIT;
        commit   = 1'b1;
      end
      default: if (en) begin
        state_nx = ST_SHIFT;
        clr      = 1'b1;
      end else begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Chain shift, bit counter with overflow marker, and the commit itself.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (en) begin
        shadow <= {shadow[CHAIN-2:0], cfg_bus.ccff_head};
        if (clr)                 cnt <= CW'(1);
        else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
      end
      if (clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (commit) begin
        cnt <= '0;
        if (commit_ok) begin
          active <= shadow[CB-1:0];
          done_q <= 1'b1;
        end else begin
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign cfg_bus.ccff_tail = shadow[CHAIN-1];
  assign cfg_bus.cfg_done  = done_q;
  assign cfg_bus.cfg_err   = err_q;

  assign carry[0] = frac_logic_cin;

  for (genvar i = 0; i < NUM_FRAC; i++) begin : g_slice
    frac_logic_slice #(.LUT_K(LUT_K)) u_slice (
      .prog_clock    (prog_clock),
      .prog_reset_n  (prog_reset_n),
      .config_enable (en),
      .cfg           (active[i*SB +: SB]),
      .lut_in        (frac_logic_in),
      .lutk1_nb      (lutk1[(i+1) % NUM_FRAC]),
      .cin           (carry[i]),
      .lutk1         (lutk1[i]),
      .cout          (carry[i+1]),
      .out           (slice_out[i])
    );
  end

  // Keep routing quiet while reconfiguring or in reset.
  assign frac_logic_out  = (en || !prog_reset_n) ? '0 : slice_out;
  assign frac_logic_cout = (en || !prog_reset_n) ? 1'b0 : carry[NUM_FRAC];

endmodule

// File: tb/tb_frac_logic_slice_array.sv
// Bench for frac_logic_slice_array: table-driven adder vectors, randomized
// configs against a reference model, and hand-written config-chain sequences.
module tb_frac_logic_slice_array;
  import frac_logic_pkg::*;

  localparam int K   = 6;
  localparam int NF  = 2;
  localparam int SB  = slice_bits(K);
  localparam int CB  = cfg_bits(K, NF);
  localparam int TTB = tt_bits(K);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int CH = CB + 1;
`else
  localparam int CH = CB;
`endif

  typedef struct {
    logic [K-1:0]  in;
    logic          ci;
    logic [NF-1:0] eout;
    logic          ecout;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [K-1:0]  lin;
  logic          cin;
  logic [NF-1:0] out;
  logic          cout;
  int            vectors = 0;
  int            miscompares = 0;
  logic [CB-1:0] act_m = '0;
  vec_t          tbl [6];

  frac_logic_slice_array_if cif ();

  frac_logic_slice_array #(.LUT_K(K), .NUM_FRAC(NF)) dut (
    .prog_clock      (clk),
    .prog_reset_n    (rst_n),
    .cfg_bus         (cif),
    .frac_logic_in   (lin),
    .frac_logic_cin  (cin),
    .frac_logic_out  (out),
    .frac_logic_cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] mk_cfg(input logic [TTB-1:0] tt0, input logic [1:0] s0,
                                           input logic r0, input logic [TTB-1:0] tt1,
                                           input logic [1:0] s1, input logic r1);
    return {r1, s1, tt1, r0, s0, tt0};
  endfunction

  // Adder truth table: low half = in0 XOR in1, high half = in0 AND in1.
  function automatic logic [TTB-1:0] adder_tt();
    logic [TTB-1:0] t;
    t = '0;
    for (int j = 0; j < TTB/2; j++) begin
      t[j]         = ((j & 1) != 0) ^ ((j & 2) != 0);
      t[TTB/2 + j] = ((j & 1) != 0) & ((j & 2) != 0);
    end
    return t;
  endfunction

  // Reference: per-slice mux values (before the output register) plus carry out.
  function automatic logic [NF:0] model(input logic [CB-1:0] c, input logic [K-1:0] in,
                                        input logic ci);
    logic [NF-1:0] res;
    logic          carry;
    carry = ci;
    res   = '0;
    for (int i = 0; i < NF; i++) begin
      logic [TTB-1:0] tt;
      logic [1:0]     s;
      logic           p, g, l5, l6, sm, co;
      tt = c[i*SB +: TTB];
      s  = c[i*SB + TTB +: 2];
      p  = tt[int'(in[K-3:0])];
      g  = tt[TTB/2 + int'(in[K-3:0])];
      l5 = tt[int'(in[K-2:0])];
      l6 = in[K-1] ? c[((i+1) % NF)*SB + int'(in[K-2:0])] : l5;
      sm = p ^ carry;
      co = p ? carry : g;
      case (s)
        2'd0:    res[i] = sm;
        2'd1:    res[i] = co;
        2'd2:    res[i] = l5;
        default: res[i] = l6;
      endcase
      carry = co;
    end
    return {carry, res};
  endfunction

  function automatic logic [NF-1:0] rmask(input logic [CB-1:0] c);
    logic [NF-1:0] r;
    for (int i = 0; i < NF; i++) r[i] = c[i*SB + TTB + 2];
    return r;
  endfunction

  function automatic logic [CH-1:0] chain_of(input logic [CB-1:0] c);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  function automatic logic [CB-1:0] rand_cfg();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[CB-1:0];
  endfunction

  // Shift n bits, MSB of v first; bits beyond the chain length are ones.
  task automatic shift_in(input logic [CH-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cif.config_enable = 1'b1;
      if (k < CH) cif.ccff_head = v[CH-1-k];
      else        cif.ccff_head = 1'b1;
    end
  endtask

  task automatic commit(input logic first_bit, input bit full, input bit ok,
                        input logic [CB-1:0] c);
    @(negedge clk);
    if (full) chk("ccff_tail_echo", cif.ccff_tail, first_bit);
    chk("done_before_commit", cif.cfg_done, 0);
    cif.config_enable = 1'b0;
    @(negedge clk);
    chk("cfg_done", cif.cfg_done, ok);
    chk("cfg_err", cif.cfg_err, !ok);
    if (ok) act_m = c;
  endtask

  task automatic load(input logic [CB-1:0] c);
    logic [CH-1:0] v;
    v = chain_of(c);
    shift_in(v, CH);
    commit(v[CH-1], 1'b1, 1'b1, c);
  endtask

  task automatic run_rand(input int n);
    logic [NF:0]   m;
    logic [NF-1:0] rm, prev, expo;
    bit            pv;
    pv   = 1'b0;
    prev = '0;
    rm   = rmask(act_m);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      lin = K'($urandom);
      cin = 1'($urandom);
      #1;
      m    = model(act_m, lin, cin);
      expo = (m[NF-1:0] & ~rm) | (prev & rm);
      chk("rand_cout", cout, m[NF]);
      if (pv) chk("rand_out", out, expo);
      else    chk("rand_out_comb", out & ~rm, m[NF-1:0] & ~rm);
      prev = m[NF-1:0];
      pv   = 1'b1;
    end
  endtask

  initial begin
    logic [CB-1:0] x;
    logic [NF:0]   m;

    tbl[0] = '{6'b000001, 1'b1, 2'b00, 1'b1};
    tbl[1] = '{6'b000000, 1'b0, 2'b00, 1'b0};
    tbl[2] = '{6'b000011, 1'b0, 2'b10, 1'b1};
    tbl[3] = '{6'b000001, 1'b0, 2'b11, 1'b0};
    tbl[4] = '{6'b000000, 1'b1, 2'b01, 1'b0};
    tbl[5] = '{6'b110010, 1'b1, 2'b00, 1'b1};

    cif.config_enable = 1'b0;
    cif.ccff_head     = 1'b0;
    lin   = 6'h2a;
    cin   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out", out, 0);
    chk("rst_cout", cout, 0);
    chk("rst_tail", cif.ccff_tail, 0);
    chk("rst_done", cif.cfg_done, 0);
    chk("rst_err", cif.cfg_err, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    m = model('0, lin, cin);
    chk("post_rst_out", out, m[NF-1:0]);

    // Ripple-carry adder in both slices.
    load(mk_cfg(adder_tt(), 2'd0, 1'b0, adder_tt(), 2'd0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lin = tbl[i].in;
      cin = tbl[i].ci;
      #1;
      chk("adder_out", out, tbl[i].eout);
      chk("adder_cout", cout, tbl[i].ecout);
    end

    // One bit short: rejected, adder config stays live.
    x = rand_cfg();
    shift_in(chain_of(x), CH - 1);
    commit(1'b0, 1'b0, 1'b0, x);
    run_rand(10);

    for (int r = 0; r < 3; r++) begin
      load(rand_cfg());
      run_rand(25);
    end

    // Asynchronous reset mid-run.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_out", out, 0);
    chk("midrun_rst_cout", cout, 0);
    chk("midrun_rst_done", cif.cfg_done, 0);
    chk("midrun_rst_err", cif.cfg_err, 0);
    chk("midrun_rst_tail", cif.ccff_tail, 0);
    @(negedge clk) rst_n = 1'b1;
    act_m = '0;

    // Registered AND of in[4:0] in slice 0.
    load(mk_cfg({1'b1, {(TTB-1){1'b0}}}, 2'd2, 1'b1, '0, 2'd0, 1'b0));
    @(negedge clk);
    lin = '0;
    cin = 1'b0;
    @(negedge clk);
    #1 chk("reg_low", out[0], 0);
    lin = K'(31);
    #1 chk("reg_not_comb", out[0], 0);
    @(negedge clk);
    #1 chk("reg_rise", out[0], 1);
    cif.config_enable = 1'b1;
    #1;
    chk("cfg_en_forced_out", out, 0);
    chk("cfg_en_forced_cout", cout, 0);
    @(negedge clk) cif.config_enable = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_err", cif.cfg_err, 1);
    chk("b2b_done", cif.cfg_done, 0);
    chk("b2b_retained", out[0], 1);

    // Overshift then reset mid-shift: no partial commit.
    shift_in('1, CH + 2);
    @(negedge clk);
    chk("overshift_tail", cif.ccff_tail, 1);
    #2 rst_n = 1'b0;
    cif.config_enable = 1'b0;
    #1;
    chk("midshift_rst_tail", cif.ccff_tail, 0);
    chk("midshift_rst_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lin   = '0;
    cin   = 1'b1;
    act_m = '0;
    #1;
    m = model(act_m, lin, cin);
    chk("midshift_rst_active", out, m[NF-1:0]);
    chk("midshift_rst_cout", cout, m[NF]);
    @(negedge clk);
    chk("midshift_rst_done", cif.cfg_done, 0);
    chk("midshift_rst_err", cif.cfg_err, 0);

`ifdef FRAC_LOGIC_CFG_PARITY_EN
    begin
      logic [CH-1:0] bad;
      x   = rand_cfg();
      bad = {~(^x), x};
      shift_in(bad, CH);
      commit(bad[CH-1], 1'b1, 1'b0, x);
      load(x);
      run_rand(10);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
